// File: rtl/deparser_rule_cfg_arbiter.sv
// Round-robin arbiter sharing one rule-configuration path between the host register
// port (read/write) and the table loader (write-only), fanned out to the deparser layers.
module deparser_rule_cfg_arbiter #(
   parameter int LAYER_NUM  = 4,
   parameter int LSEL_LSB   = 24,
   parameter int RD_TIMEOUT = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_host_req,
   input  logic                   i_host_we,
   input  logic [31:0]            i_host_addr,
   input  logic [31:0]            i_host_wdata,
   output logic                   o_host_gnt,
   output logic                   o_host_rvalid,
   output logic [31:0]            o_host_rdata,
   output logic                   o_host_err,
   input  logic                   i_ld_req,
   input  logic [31:0]            i_ld_addr,
   input  logic [31:0]            i_ld_wdata,
   output logic                   o_ld_gnt,
   output logic                   o_ld_err,
   output logic [LAYER_NUM-1:0]   o_rule_wren,
   output logic [LAYER_NUM-1:0]   o_rule_rden,
   output logic [31:0]            o_rule_addr,
   output logic [31:0]            o_rule_wdata,
   input  logic [LAYER_NUM-1:0]   i_rule_rdata_valid,
   input  logic [LAYER_NUM*32-1:0] i_rule_rdata,
   output logic                   o_busy,
   output logic [15:0]            o_err_cnt
);

   localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 2);
   localparam int PAD_W = 16 * 32;

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

   state_t            state, state_n;
   logic              prio_ld, prio_ld_n;
   logic              cur_ld, cur_ld_n;
   logic              cur_we, cur_we_n;
   logic              cur_ok, cur_ok_n;
   logic [3:0]        cur_layer, cur_layer_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              rsp_valid;
   logic [31:0]       rsp_data;

   logic              sel_ld;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic [3:0]        sel_layer;
   logic              sel_ok;
   logic [15:0]       strobe16;
   logic [15:0]       valid_pad;
   logic [PAD_W-1:0]  rdata_pad;
   logic              lane_valid;
   logic [31:0]       lane_data;

   logic [LAYER_NUM-1:0] wren_n, rden_n;
   logic [31:0]       rule_addr_n, rule_wdata_n;
   logic              host_gnt_n, ld_gnt_n, host_err_n, ld_err_n;
   logic              cap_valid_n, timeout_n;
   logic [31:0]       cap_data_n;
   logic [16:0]       err_sum;
   logic [15:0]       err_cnt_n;
   logic              unused_bits;

   assign unused_bits = ^{sel_addr, strobe16};

   // Arbitration, layer decode and the transaction sequencer; every result is a
   // next-value that the register process below turns into an output.
   always_comb begin
      sel_ld       = i_ld_req & (~i_host_req | prio_ld);
      sel_addr     = sel_ld ? i_ld_addr : i_host_addr;
      sel_wdata    = sel_ld ? i_ld_wdata : i_host_wdata;
      sel_layer    = sel_addr[LSEL_LSB +: 4];
      sel_ok       = ({28'd0, sel_layer} < 32'(LAYER_NUM));
      strobe16     = 16'd1 << sel_layer;
      valid_pad    = 16'(i_rule_rdata_valid);
      rdata_pad    = PAD_W'(i_rule_rdata);
      lane_valid   = valid_pad[cur_layer];
      lane_data    = rdata_pad[{cur_layer, 5'd0} +: 32];

      state_n      = state;
      prio_ld_n    = prio_ld;
      cur_ld_n     = cur_ld;
      cur_we_n     = cur_we;
      cur_ok_n     = cur_ok;
      cur_layer_n  = cur_layer;
      cnt_n        = cnt;
      wren_n       = '0;
      rden_n       = '0;
      rule_addr_n  = o_rule_addr;
      rule_wdata_n = o_rule_wdata;
      host_gnt_n   = 1'b0;
      ld_gnt_n     = 1'b0;
      host_err_n   = 1'b0;
      ld_err_n     = 1'b0;
      cap_valid_n  = 1'b0;
      cap_data_n   = '0;
      timeout_n    = 1'b0;

      case (state)
         IDLE: begin
            if (i_host_req || i_ld_req) begin
               prio_ld_n    = ~sel_ld;
               cur_ld_n     = sel_ld;
               cur_we_n     = sel_ld | i_host_we;
               cur_ok_n     = sel_ok;
               cur_layer_n  = sel_layer;
               rule_addr_n  = 32'(sel_addr[LSEL_LSB-1:0]);
               rule_wdata_n = sel_wdata;
               host_gnt_n   = ~sel_ld;
               ld_gnt_n     = sel_ld;
               if (sel_ok) begin
                  if (sel_ld | i_host_we) wren_n = strobe16[LAYER_NUM-1:0];
                  else                    rden_n = strobe16[LAYER_NUM-1:0];
               end
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            state_n = IDLE;
            if (!cur_ok) begin
               host_err_n = ~cur_ld;
               ld_err_n   = cur_ld;
            end else if (!cur_we) begin
               if (lane_valid) begin
                  cap_valid_n = 1'b1;
                  cap_data_n  = lane_data;
               end else begin
                  cnt_n   = '0;
                  state_n = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // A late valid on the final waiting cycle still beats the timeout.
            if (lane_valid) begin
               cap_valid_n = 1'b1;
               cap_data_n  = lane_data;
               state_n     = IDLE;
            end else if (cnt == CNT_LAST) begin
               host_err_n = 1'b1;
               timeout_n  = 1'b1;
               state_n    = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      err_sum   = 17'(o_err_cnt) + 17'(host_err_n) + 17'(ld_err_n);
      err_cnt_n = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   // Read data passes through one capture stage before reaching the host port.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         prio_ld       <= 1'b0;
         cur_ld        <= 1'b0;
         cur_we        <= 1'b0;
         cur_ok        <= 1'b0;
         cur_layer     <= '0;
         cnt           <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         o_host_gnt    <= 1'b0;
         o_host_rvalid <= 1'b0;
         o_host_rdata  <= '0;
         o_host_err    <= 1'b0;
         o_ld_gnt      <= 1'b0;
         o_ld_err      <= 1'b0;
         o_rule_wren   <= '0;
         o_rule_rden   <= '0;
         o_rule_addr   <= '0;
         o_rule_wdata  <= '0;
         o_busy        <= 1'b0;
         o_err_cnt     <= '0;
      end else begin
         state         <= state_n;
         prio_ld       <= prio_ld_n;
         cur_ld        <= cur_ld_n;
         cur_we        <= cur_we_n;
         cur_ok        <= cur_ok_n;
         cur_layer     <= cur_layer_n;
         cnt           <= cnt_n;
         rsp_valid     <= cap_valid_n;
         if (cap_valid_n) rsp_data <= cap_data_n;
         o_host_gnt    <= host_gnt_n;
         o_host_rvalid <= rsp_valid;
         if (rsp_valid)      o_host_rdata <= rsp_data;
         else if (timeout_n) o_host_rdata <= '0;
         o_host_err    <= host_err_n;
         o_ld_gnt      <= ld_gnt_n;
         o_ld_err      <= ld_err_n;
         o_rule_wren   <= wren_n;
         o_rule_rden   <= rden_n;
         o_rule_addr   <= rule_addr_n;
         o_rule_wdata  <= rule_wdata_n;
         o_busy        <= (state_n != IDLE);
         o_err_cnt     <= err_cnt_n;
      end
   end

endmodule

// File: tb/tb_deparser_rule_cfg_arbiter.sv
// Scoreboard bench for deparser_rule_cfg_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT presents grants, read data and errors.
module tb_deparser_rule_cfg_arbiter;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_host_req, i_host_we, i_ld_req;
   logic [31:0]  i_host_addr, i_host_wdata, i_ld_addr, i_ld_wdata;
   logic         o_host_gnt, o_host_rvalid, o_host_err, o_ld_gnt, o_ld_err, o_busy;
   logic [31:0]  o_host_rdata, o_rule_addr, o_rule_wdata;
   logic [3:0]   o_rule_wren, o_rule_rden, i_rule_rdata_valid;
   logic [127:0] i_rule_rdata;
   logic [15:0]  o_err_cnt;

   deparser_rule_cfg_arbiter dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
      .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
      .o_host_rdata(o_host_rdata), .o_host_err(o_host_err),
      .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata),
      .o_ld_gnt(o_ld_gnt), .o_ld_err(o_ld_err),
      .o_rule_wren(o_rule_wren), .o_rule_rden(o_rule_rden), .o_rule_addr(o_rule_addr),
      .o_rule_wdata(o_rule_wdata), .i_rule_rdata_valid(i_rule_rdata_valid),
      .i_rule_rdata(i_rule_rdata), .o_busy(o_busy), .o_err_cnt(o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // kind: 0 grant/strobe, 1 host read response, 2 host error, 3 loader error
   typedef struct {
      int          kind;
      int          cyc;
      logic        ld;
      logic [3:0]  wren;
      logic [3:0]  rden;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] errcnt;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   logic [31:0] h_addr  [4] = '{32'h0000_0004, 32'h02AB_CDEF, 32'hF100_0001, 32'h0300_0000};
   logic [3:0]  h_wren  [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
   logic [31:0] h_raddr [4] = '{32'h0000_0004, 32'h00AB_CDEF, 32'h0000_0001, 32'h0000_0000};
   logic [31:0] l_addr  [4] = '{32'h0100_0020, 32'h0312_3456, 32'h0000_0000, 32'h02FF_FFFF};
   logic [3:0]  l_wren  [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};
   logic [31:0] l_raddr [4] = '{32'h0000_0020, 32'h0012_3456, 32'h0000_0000, 32'h00FF_FFFF};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pushEvent(input int kind, input int c, input logic ld, input logic [3:0] wren,
                            input logic [3:0] rden, input logic [31:0] addr,
                            input logic [31:0] data, input logic [15:0] errcnt);
      exp_t e;
      e.kind = kind; e.cyc = c; e.ld = ld; e.wren = wren; e.rden = rden;
      e.addr = addr; e.data = data; e.errcnt = errcnt;
      q.push_back(e);
   endtask

   // Raises one request at the current negedge and drops it at the grant negedge.
   task automatic applyStimulus(input logic ld, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      if (ld) begin
         i_ld_req = 1'b1; i_ld_addr = addr; i_ld_wdata = wdata;
      end else begin
         i_host_req = 1'b1; i_host_we = we; i_host_addr = addr; i_host_wdata = wdata;
      end
      @(negedge i_clk);
      i_host_req = 1'b0;
      i_ld_req   = 1'b0;
   endtask

   task automatic popExp(input int kind, output exp_t e, output bit ok);
      ok = 1'b0;
      if (q.size() == 0) begin
         n_assert++;
         n_fail++;
         $display("[TB] FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
      end else begin
         e  = q.pop_front();
         ok = 1'b1;
         checkOutput("event_kind", kind, e.kind);
         checkOutput("event_cycle", cyc, e.cyc);
      end
   endtask

   exp_t mon_e;
   bit   mon_ok;

   always @(negedge i_clk) begin
      if (!i_rst) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_assert++;
            n_fail++;
            $display("[TB] FAIL missing_event: kind %0d expected at cycle %0d, none by cycle %0d",
                     q[0].kind, q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (o_host_gnt || o_ld_gnt || (|o_rule_wren) || (|o_rule_rden)) begin
            popExp(0, mon_e, mon_ok);
            if (mon_ok) begin
               checkOutput("host_gnt", o_host_gnt, !mon_e.ld);
               checkOutput("ld_gnt", o_ld_gnt, mon_e.ld);
               checkOutput("rule_wren", o_rule_wren, mon_e.wren);
               checkOutput("rule_rden", o_rule_rden, mon_e.rden);
               checkOutput("rule_addr", o_rule_addr, mon_e.addr);
               checkOutput("rule_wdata", o_rule_wdata, mon_e.data);
            end
         end
         if (o_host_rvalid) begin
            popExp(1, mon_e, mon_ok);
            if (mon_ok) checkOutput("host_rdata", o_host_rdata, mon_e.data);
         end
         if (o_host_err) begin
            popExp(2, mon_e, mon_ok);
            if (mon_ok) begin
               checkOutput("err_rdata", o_host_rdata, mon_e.data);
               checkOutput("err_cnt_host", o_err_cnt, mon_e.errcnt);
            end
         end
         if (o_ld_err) begin
            popExp(3, mon_e, mon_ok);
            if (mon_ok) checkOutput("err_cnt_ld", o_err_cnt, mon_e.errcnt);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      i_rst = 1'b1;
      i_host_req = 0; i_host_we = 0; i_host_addr = 0; i_host_wdata = 0;
      i_ld_req = 0; i_ld_addr = 0; i_ld_wdata = 0;
      i_rule_rdata_valid = 0;
      i_rule_rdata = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
      repeat (3) @(negedge i_clk);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_err_cnt", o_err_cnt, 0);
      checkOutput("rst_rdata", o_host_rdata, 0);
      checkOutput("rst_strobes", {o_rule_wren, o_rule_rden}, 0);
      checkOutput("rst_gnt", {o_host_gnt, o_ld_gnt, o_host_rvalid, o_host_err, o_ld_err}, 0);
      i_rst = 1'b0;
      @(negedge i_clk);

      $display("[TB] simultaneous host/loader writes");
      for (int r = 0; r < 4; r++) begin
         t = cyc;
         pushEvent(0, t + 1, 1'b0, h_wren[r], 4'b0, h_raddr[r], 32'h1111_0000 + r, 0);
         pushEvent(0, t + 3, 1'b1, l_wren[r], 4'b0, l_raddr[r], 32'h2222_0000 + r, 0);
         i_host_req = 1; i_host_we = 1; i_host_addr = h_addr[r]; i_host_wdata = 32'h1111_0000 + r;
         i_ld_req = 1; i_ld_addr = l_addr[r]; i_ld_wdata = 32'h2222_0000 + r;
         @(negedge i_clk);
         i_host_req = 0;
         repeat (2) @(negedge i_clk);
         i_ld_req = 0;
         @(negedge i_clk);
      end
      repeat (2) @(negedge i_clk);

      $display("[TB] host write layer 2");
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0100, 4'b0, 32'h10, 32'hA5A5_0001, 0);
      applyStimulus(1'b0, 1'b1, 32'h0200_0010, 32'hA5A5_0001);
      checkOutput("busy_issue", o_busy, 1);
      repeat (2) @(negedge i_clk);
      checkOutput("busy_idle", o_busy, 0);

      $display("[TB] zero-wait read layer 1");
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0, 4'b0010, 32'h8, 32'h0, 0);
      pushEvent(1, t + 3, 1'b0, 4'b0, 4'b0, 0, 32'hCAFE_0001, 0);
      applyStimulus(1'b0, 1'b0, 32'h0100_0008, 32'h0);
      i_rule_rdata[32 +: 32] = 32'hCAFE_0001; i_rule_rdata_valid = 4'b0010;
      @(negedge i_clk);
      i_rule_rdata_valid = 0;
      repeat (4) @(negedge i_clk);

      $display("[TB] read layer 1, valid three cycles after rden");
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0, 4'b0010, 32'h20, 32'h0, 0);
      pushEvent(1, t + 6, 1'b0, 4'b0, 4'b0, 0, 32'h1234_5678, 0);
      applyStimulus(1'b0, 1'b0, 32'h0100_0020, 32'h0);
      @(negedge i_clk);
      i_rule_rdata_valid = 4'b0100;
      @(negedge i_clk);
      i_rule_rdata_valid = 0;
      @(negedge i_clk);
      i_rule_rdata[32 +: 32] = 32'h1234_5678; i_rule_rdata_valid = 4'b0010;
      @(negedge i_clk);
      i_rule_rdata_valid = 0;
      repeat (4) @(negedge i_clk);

      $display("[TB] read layer 2, valid on the last waiting cycle");
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0, 4'b0100, 32'h100, 32'h0, 0);
      pushEvent(1, t + 18, 1'b0, 4'b0, 4'b0, 0, 32'h5EED_0016, 0);
      applyStimulus(1'b0, 1'b0, 32'h0200_0100, 32'h0);
      repeat (15) @(negedge i_clk);
      i_rule_rdata[64 +: 32] = 32'h5EED_0016; i_rule_rdata_valid = 4'b0100;
      @(negedge i_clk);
      i_rule_rdata_valid = 0;
      repeat (4) @(negedge i_clk);

      $display("[TB] read layer 3 timeout");
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0, 4'b1000, 32'h40, 32'h0, 0);
      pushEvent(2, t + 17, 1'b0, 4'b0, 4'b0, 0, 32'h0, 16'd1);
      applyStimulus(1'b0, 1'b0, 32'h0300_0040, 32'h0);
      repeat (20) @(negedge i_clk);

      $display("[TB] out-of-range layers");
      t = cyc;
      pushEvent(0, t + 1, 1'b1, 4'b0, 4'b0, 32'h0, 32'h7777_0005, 0);
      pushEvent(3, t + 2, 1'b1, 4'b0, 4'b0, 0, 0, 16'd2);
      applyStimulus(1'b1, 1'b1, 32'h0500_0000, 32'h7777_0005);
      repeat (3) @(negedge i_clk);
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0, 4'b0, 32'h0, 32'h0, 0);
      pushEvent(2, t + 2, 1'b0, 4'b0, 4'b0, 0, 32'h0, 16'd3);
      applyStimulus(1'b0, 1'b0, 32'h0F00_0000, 32'h0);
      repeat (3) @(negedge i_clk);
      checkOutput("err_cnt_total", o_err_cnt, 16'd3);

      $display("[TB] reset during read wait");
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0, 4'b0001, 32'h8, 32'h0, 0);
      applyStimulus(1'b0, 1'b0, 32'h0000_0008, 32'h0);
      repeat (2) @(negedge i_clk);
      checkOutput("busy_rd_wait", o_busy, 1);
      i_rst = 1'b1;
      #1;
      checkOutput("abort_busy", o_busy, 0);
      checkOutput("abort_err_cnt", o_err_cnt, 0);
      checkOutput("abort_rule_addr", o_rule_addr, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      i_rule_rdata[0 +: 32] = 32'hDEAD_0000; i_rule_rdata_valid = 4'b0001;
      @(negedge i_clk);
      i_rule_rdata_valid = 0;
      repeat (4) @(negedge i_clk);
      t = cyc;
      pushEvent(0, t + 1, 1'b0, 4'b0100, 4'b0, 32'h10, 32'hA5A5_0002, 0);
      applyStimulus(1'b0, 1'b1, 32'h0200_0010, 32'hA5A5_0002);
      repeat (3) @(negedge i_clk);

      for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge i_clk);
      checkOutput("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
